// File: rtl/packetfilt_slot_scheduler.sv
// Slot scheduler for the parallel packet filter: allocates slots to the snooper,
// launches per-slot VMs, collects verdicts and releases accepted packets in arrival order.
module packetfilt_slot_scheduler #(
  parameter int N         = 5,
  parameter int SEL_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 enable,
  input  logic                 snooper_done,
  input  logic                 snooper_drop,
  output logic                 ready_for_snooper,
  output logic [SEL_WIDTH-1:0] snoop_sel,
  output logic [N-1:0]         filt_start,
  input  logic [N-1:0]         filt_done,
  input  logic [N-1:0]         filt_accept,
  output logic                 ready_for_forwarder,
  output logic [SEL_WIDTH-1:0] fwd_sel,
  input  logic                 forwarder_done,
  output logic [CNT_WIDTH-1:0] num_packets_dropped,
  output logic [N-1:0]         slots_busy
);

  localparam int CW = SEL_WIDTH + 1;

  typedef enum logic [2:0] {S_FREE, S_FILL, S_FILT, S_ACC, S_REJ} slot_state_t;

  logic [N-1:0]         free_vec, fill_vec, acc_vec, rej_vec;
  logic [SEL_WIDTH-1:0] fifo_mem [N];
  logic [SEL_WIDTH-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]        count_reg;

  logic                 ready_for_snooper_reg, ready_for_forwarder_reg;
  logic [SEL_WIDTH-1:0] snoop_sel_reg, fwd_sel_reg;
  logic [N-1:0]         filt_start_reg;
  logic [CNT_WIDTH-1:0] drop_cnt_reg;

  logic                 alloc_found, alloc_valid, push, pop, head_valid;
  logic                 ready_for_forwarder_next;
  logic [SEL_WIDTH-1:0] alloc_idx, head_idx;

  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_idx   = SEL_WIDTH'(i);
        alloc_found = 1'b1;
      end
    end
  end

  // Only one slot may be in FILL, so allocation waits until the current fill is handed off.
  assign alloc_valid = enable && alloc_found && !(|fill_vec);
  assign push        = enable && snooper_done && ready_for_snooper_reg;
  assign head_valid  = (count_reg != '0);
  assign head_idx    = fifo_mem[rd_ptr_reg];
  assign pop         = enable && head_valid &&
                       (rej_vec[head_idx] || (ready_for_forwarder_reg && forwarder_done));
  assign ready_for_forwarder_next = head_valid && acc_vec[head_idx] &&
                                    !(ready_for_forwarder_reg && forwarder_done);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      slot_state_t state_reg;

      always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
          state_reg <= S_FREE;
        end else if (!enable) begin
          state_reg <= S_FREE;
        end else begin
          case (state_reg)
            S_FREE: if (alloc_valid && alloc_idx == SEL_WIDTH'(gi)) state_reg <= S_FILL;
            S_FILL: if (push) state_reg <= S_FILT;
            S_FILT: if (filt_done[gi]) state_reg <= filt_accept[gi] ? S_ACC : S_REJ;
            S_ACC, S_REJ: if (pop && head_idx == SEL_WIDTH'(gi)) state_reg <= S_FREE;
            default: state_reg <= S_FREE;
          endcase
        end
      end

      assign free_vec[gi] = (state_reg == S_FREE);
      assign fill_vec[gi] = (state_reg == S_FILL);
      assign acc_vec[gi]  = (state_reg == S_ACC);
      assign rej_vec[gi]  = (state_reg == S_REJ);
    end
  endgenerate

  // Order FIFO storage needs no reset: entries are only read while count_reg covers them.
  always_ff @(posedge axi_aclk) begin
    if (push) fifo_mem[wr_ptr_reg] <= snoop_sel_reg;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_ptr_reg              <= '0;
      wr_ptr_reg              <= '0;
      count_reg               <= '0;
      ready_for_snooper_reg   <= 1'b0;
      snoop_sel_reg           <= '0;
      filt_start_reg          <= '0;
      ready_for_forwarder_reg <= 1'b0;
      fwd_sel_reg             <= '0;
      drop_cnt_reg            <= '0;
    end else if (!enable) begin
      rd_ptr_reg              <= '0;
      wr_ptr_reg              <= '0;
      count_reg               <= '0;
      ready_for_snooper_reg   <= 1'b0;
      snoop_sel_reg           <= '0;
      filt_start_reg          <= '0;
      ready_for_forwarder_reg <= 1'b0;
      fwd_sel_reg             <= '0;
    end else begin
      filt_start_reg <= push ? (N'(1) << snoop_sel_reg) : '0;

      if (push) begin
        ready_for_snooper_reg <= 1'b0;
      end else if (alloc_valid) begin
        ready_for_snooper_reg <= 1'b1;
        snoop_sel_reg         <= alloc_idx;
      end

      if (push) wr_ptr_reg <= (wr_ptr_reg == SEL_WIDTH'(N - 1)) ? '0 : wr_ptr_reg + SEL_WIDTH'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == SEL_WIDTH'(N - 1)) ? '0 : rd_ptr_reg + SEL_WIDTH'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);

      ready_for_forwarder_reg <= ready_for_forwarder_next;
      if (ready_for_forwarder_next) fwd_sel_reg <= head_idx;

      if (snooper_drop && drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign ready_for_snooper   = ready_for_snooper_reg;
  assign snoop_sel           = snoop_sel_reg;
  assign filt_start          = filt_start_reg;
  assign ready_for_forwarder = ready_for_forwarder_reg;
  assign fwd_sel             = fwd_sel_reg;
  assign num_packets_dropped = drop_cnt_reg;
  assign slots_busy          = ~free_vec;

endmodule

// File: tb/tb_packetfilt_slot_scheduler.sv
// Directed bench for packetfilt_slot_scheduler: hand-computed expectations for
// allocation, verdict ordering, drop counting, simultaneous events and clearing.
module tb_packetfilt_slot_scheduler;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        snooper_done = 1'b0;
  logic        snooper_drop = 1'b0;
  logic        ready_for_snooper;
  logic [2:0]  snoop_sel;
  logic [4:0]  filt_start;
  logic [4:0]  filt_done = '0;
  logic [4:0]  filt_accept = '0;
  logic        ready_for_forwarder;
  logic [2:0]  fwd_sel;
  logic        forwarder_done = 1'b0;
  logic [15:0] num_packets_dropped;
  logic [4:0]  slots_busy;

  int n_cmp = 0;
  int n_err = 0;

  packetfilt_slot_scheduler #(.N(5), .SEL_WIDTH(3), .CNT_WIDTH(16)) dut (
    .axi_aclk           (axi_aclk),
    .axi_aresetn        (axi_aresetn),
    .enable             (enable),
    .snooper_done       (snooper_done),
    .snooper_drop       (snooper_drop),
    .ready_for_snooper  (ready_for_snooper),
    .snoop_sel          (snoop_sel),
    .filt_start         (filt_start),
    .filt_done          (filt_done),
    .filt_accept        (filt_accept),
    .ready_for_forwarder(ready_for_forwarder),
    .fwd_sel            (fwd_sel),
    .forwarder_done     (forwarder_done),
    .num_packets_dropped(num_packets_dropped),
    .slots_busy         (slots_busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  // One packet handoff from the snooper, then the allocation cycle.
  task automatic fill_one();
    snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    tick();
  endtask

  task automatic verdict(input int slot, input logic acc);
    filt_done[slot]   = 1'b1;
    filt_accept[slot] = acc;
    tick();
    filt_done   = '0;
    filt_accept = '0;
  endtask

  task automatic fwd_done();
    forwarder_done = 1'b1;
    tick();
    forwarder_done = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_val("rst ready_for_snooper", 32'(ready_for_snooper), 32'h0);
    check_val("rst ready_for_forwarder", 32'(ready_for_forwarder), 32'h0);
    check_val("rst filt_start", 32'(filt_start), 32'h0);
    check_val("rst slots_busy", 32'(slots_busy), 32'h0);
    check_val("rst drop_count", 32'(num_packets_dropped), 32'h0);

    // First allocation one cycle after enable
    axi_aresetn = 1'b1;
    enable      = 1'b1;
    tick();
    check_val("alloc0 ready_for_snooper", 32'(ready_for_snooper), 32'h1);
    check_val("alloc0 snoop_sel", 32'(snoop_sel), 32'h0);
    check_val("alloc0 slots_busy", 32'(slots_busy), 32'h01);
    check_val("alloc0 ready_for_forwarder", 32'(ready_for_forwarder), 32'h0);

    // Single packet: fill, filter, accept, forward
    snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    check_val("pkt0 filt_start", 32'(filt_start), 32'h01);
    check_val("pkt0 ready_for_snooper gap", 32'(ready_for_snooper), 32'h0);
    tick();
    check_val("pkt0 filt_start cleared", 32'(filt_start), 32'h0);
    check_val("alloc1 ready_for_snooper", 32'(ready_for_snooper), 32'h1);
    check_val("alloc1 snoop_sel", 32'(snoop_sel), 32'h1);
    verdict(0, 1'b1);
    check_val("pkt0 fwd not yet", 32'(ready_for_forwarder), 32'h0);
    tick();
    check_val("pkt0 ready_for_forwarder", 32'(ready_for_forwarder), 32'h1);
    check_val("pkt0 fwd_sel", 32'(fwd_sel), 32'h0);
    fwd_done();
    check_val("pkt0 fwd released", 32'(ready_for_forwarder), 32'h0);
    check_val("pkt0 slots_busy", 32'(slots_busy), 32'h02);

    // Soft clear, then three packets with out-of-order verdicts
    enable = 1'b0;
    tick();
    check_val("clear slots_busy", 32'(slots_busy), 32'h0);
    check_val("clear ready_for_snooper", 32'(ready_for_snooper), 32'h0);
    enable = 1'b1;
    tick();
    fill_one();
    fill_one();
    fill_one();
    check_val("ooo slots_busy", 32'(slots_busy), 32'h0F);
    check_val("ooo snoop_sel", 32'(snoop_sel), 32'h3);
    verdict(2, 1'b1);
    verdict(1, 1'b0);
    check_val("ooo no overtake", 32'(ready_for_forwarder), 32'h0);
    verdict(0, 1'b1);
    tick();
    check_val("ooo first ready", 32'(ready_for_forwarder), 32'h1);
    check_val("ooo first fwd_sel", 32'(fwd_sel), 32'h0);
    fwd_done();
    check_val("ooo gap after fwd", 32'(ready_for_forwarder), 32'h0);
    tick();
    check_val("ooo rej pop no fwd", 32'(ready_for_forwarder), 32'h0);
    check_val("ooo rej freed busy", 32'(slots_busy), 32'h0C);
    tick();
    check_val("ooo second ready", 32'(ready_for_forwarder), 32'h1);
    check_val("ooo second fwd_sel", 32'(fwd_sel), 32'h2);
    fwd_done();
    check_val("ooo done busy", 32'(slots_busy), 32'h08);

    // Fill all five slots (order 3,0,1,2,4), then drops
    repeat (5) fill_one();
    check_val("full ready_for_snooper", 32'(ready_for_snooper), 32'h0);
    check_val("full slots_busy", 32'(slots_busy), 32'h1F);
    snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    check_val("full done ignored", 32'(filt_start), 32'h0);
    repeat (3) begin
      snooper_drop = 1'b1;
      tick();
      snooper_drop = 1'b0;
      tick();
    end
    check_val("drop count 3", 32'(num_packets_dropped), 32'h3);
    snooper_drop = 1'b1;
    repeat (65531) tick();
    snooper_drop = 1'b0;
    check_val("drop count near top", 32'(num_packets_dropped), 32'hFFFE);
    snooper_drop = 1'b1;
    tick();
    snooper_drop = 1'b0;
    check_val("drop count top", 32'(num_packets_dropped), 32'hFFFF);
    snooper_drop = 1'b1;
    tick();
    snooper_drop = 1'b0;
    check_val("drop count saturated", 32'(num_packets_dropped), 32'hFFFF);

    // Simultaneous snooper_done, filt_done and forwarder_done
    enable = 1'b0;
    tick();
    check_val("clear2 drop held", 32'(num_packets_dropped), 32'hFFFF);
    enable = 1'b1;
    tick();
    fill_one();
    fill_one();
    fill_one();
    verdict(0, 1'b1);
    tick();
    check_val("sim pre fwd_sel", 32'(fwd_sel), 32'h0);
    check_val("sim pre ready", 32'(ready_for_forwarder), 32'h1);
    snooper_done   = 1'b1;
    filt_done[1]   = 1'b1;
    filt_accept[1] = 1'b1;
    forwarder_done = 1'b1;
    tick();
    snooper_done   = 1'b0;
    filt_done      = '0;
    filt_accept    = '0;
    forwarder_done = 1'b0;
    check_val("sim filt_start", 32'(filt_start), 32'h08);
    check_val("sim slots_busy", 32'(slots_busy), 32'h0E);
    check_val("sim ready_for_forwarder", 32'(ready_for_forwarder), 32'h0);
    check_val("sim ready_for_snooper", 32'(ready_for_snooper), 32'h0);
    tick();
    check_val("sim next ready", 32'(ready_for_forwarder), 32'h1);
    check_val("sim next fwd_sel", 32'(fwd_sel), 32'h1);
    check_val("sim realloc snoop_sel", 32'(snoop_sel), 32'h0);
    check_val("sim realloc busy", 32'(slots_busy), 32'h0F);

    // Enable dropped mid-forward with three busy slots
    fwd_done();
    verdict(2, 1'b1);
    tick();
    check_val("mid fwd_sel", 32'(fwd_sel), 32'h2);
    check_val("mid slots_busy", 32'(slots_busy), 32'h0D);
    enable = 1'b0;
    tick();
    check_val("dis slots_busy", 32'(slots_busy), 32'h0);
    check_val("dis ready_for_forwarder", 32'(ready_for_forwarder), 32'h0);
    check_val("dis drop held", 32'(num_packets_dropped), 32'hFFFF);

    // Asynchronous reset between clock edges
    enable = 1'b1;
    tick();
    check_val("pre-areset ready_for_snooper", 32'(ready_for_snooper), 32'h1);
    #2;
    axi_aresetn = 1'b0;
    #1;
    check_val("areset ready_for_snooper", 32'(ready_for_snooper), 32'h0);
    check_val("areset slots_busy", 32'(slots_busy), 32'h0);
    check_val("areset drop_count", 32'(num_packets_dropped), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/packetfilt_slot_scheduler.md
Name: packetfilt_slot_scheduler

Overview:
- Scheduler that shares the N packet-buffer/BPFVM slots of the parallel filter among the snooper, the filter engines and the forwarder.
- Allocates a free slot to each incoming packet, launches that slot's VM, collects accept/reject verdicts, and hands accepted packets to the forwarder in strict arrival order.
- Sits between axistream_snooper, parallel_packetfilts slot logic and axistream_forwarder; exports a drop counter for the Status register.

Parameters:
- N, 5, number of slots/BPFVMs (2..8)
- SEL_WIDTH, 3, slot index width; must be >= ceil(log2(N))
- CNT_WIDTH, 16, width of drop counter

Ports:
- axi_aclk  in  1  clock; all logic on rising edge
- axi_aresetn  in  1  asynchronous active-low reset
- enable  in  1  control_start; low = synchronous soft clear
- snooper_done  in  1  1-cycle pulse: packet fully written into slot snoop_sel
- snooper_drop  in  1  1-cycle pulse: snooper saw a packet start while ready_for_snooper=0
- ready_for_snooper  out  1  a slot is allocated to the snooper
- snoop_sel  out  SEL_WIDTH  slot the snooper writes; valid while ready_for_snooper=1
- filt_start  out  N  one-hot 1-cycle pulse launching VM i
- filt_done  in  N  per-slot 1-cycle verdict pulse
- filt_accept  in  N  verdict qualifier, sampled with filt_done[i]
- ready_for_forwarder  out  1  head-of-order slot is accepted and may be forwarded
- fwd_sel  out  SEL_WIDTH  slot the forwarder reads; valid while ready_for_forwarder=1
- forwarder_done  in  1  1-cycle pulse: forwarding of fwd_sel complete
- num_packets_dropped  out  CNT_WIDTH  saturating count of snooper_drop pulses
- slots_busy  out  N  bit i = slot i not FREE

Behaviour:
- Per-slot state: FREE, FILL, FILT, ACC, REJ. Order FIFO of N entries (SEL_WIDTH each) with read/write pointers mod N and count 0..N.
- Async reset: all slots FREE, FIFO empty, every output 0, counter 0.
- enable=0: next edge forces reset state except num_packets_dropped, which holds; all inputs ignored while low.
- Allocation:
  - When no slot is in FILL and any slot is FREE, the lowest-index FREE slot goes to FILL on the next edge.
  - ready_for_snooper=1 and snoop_sel=index from that edge on.
  - Exactly one slot is in FILL at a time.
- snooper_done with ready_for_snooper=1:
  - FILL slot -> FILT and its index is pushed to the FIFO.
  - filt_start[slot] pulses in the cycle after done.
  - ready_for_snooper is 0 for that cycle at minimum, then reallocates per the rule above.
  - snooper_done with ready_for_snooper=0 is ignored.
- filt_done[i] with slot i in FILT: -> ACC if filt_accept[i]=1, else -> REJ. Ignored in any other state. Multiple filt_done bits in one cycle are all processed.
- FIFO head in REJ: slot -> FREE and pop, one cycle per rejected head; no forwarder activity.
- FIFO head in ACC:
  - ready_for_forwarder=1 and fwd_sel=head, registered, beginning the cycle after the head reaches ACC.
  - forwarder_done: slot -> FREE, pop; ready_for_forwarder=0 the next cycle (min 1-cycle gap). forwarder_done while not ready is ignored.
  - A later slot reaching ACC never overtakes a head still in FILT.
- Simultaneous events in one cycle (snooper_done, filt_done, head pop/forwarder_done) are all applied; FIFO push and pop in the same cycle leave count unchanged.
- A slot freed in cycle t may be allocated at edge t+1.
- Counter: +1 per snooper_drop, saturates at all-ones, no wrap.
- FIFO cannot overflow, since at most N slots are non-FREE. An N-slot full condition simply withholds ready_for_snooper.

Test Plan:
- Reset, enable=1 -> slot 0 allocated: ready_for_snooper=1, snoop_sel=0 one cycle after enable; all other outputs 0.
- snooper_done on slot 0 -> filt_start=5'b00001 one cycle later; slot 1 allocated. filt_done[0] with accept=1 -> ready_for_forwarder=1, fwd_sel=0. forwarder_done -> slots_busy[0]=0.
- Packets into slots 0,1,2; verdicts arrive in order 2(acc),1(rej),0(acc) -> forwarder sees fwd_sel=0, then fwd_sel=2; slot 1 is freed without ready_for_forwarder.
- Fill all 5 slots, no verdicts -> ready_for_snooper=0. Three snooper_drop pulses -> num_packets_dropped=3. Preload the counter to 0xFFFF, then pulse snooper_drop -> counter stays 0xFFFF.
- Same cycle: snooper_done (slot 3), filt_done[1] accept, forwarder_done for slot 0 -> all three transitions applied; FIFO count unchanged; next head is fwd_sel=1.
- enable dropped mid-forward with 3 busy slots -> next cycle slots_busy=0, ready_for_forwarder=0, drop count held. Asserting axi_aresetn low asynchronously -> all outputs 0 immediately.
